// File: rtl/arith_rr_scheduler.sv
`default_nettype none
// =============================================================================
// Module : arith_rr_scheduler -- round-robin sharing of one fixed-latency
//          arithmetic unit between N requesters. Option: ARB_GRANT_CNT_EN.
// Rev    : 1.0
// =============================================================================
module arith_rr_scheduler #(
    parameter int M   = 32,
    parameter int N   = 4,
    parameter int LAT = 1,
    parameter int IDW = $clog2(N)
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [N*M-1:0]   req_A,
    input  logic [N*M-1:0]   req_B,
    input  logic [N*4-1:0]   req_op,
    output logic [M-1:0]     o_arg_A,
    output logic [M-1:0]     o_arg_B,
    output logic [3:0]       o_op,
    input  logic [M-1:0]     i_result,
    input  logic [3:0]       i_status,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [M-1:0]     rsp_result,
    output logic [3:0]       rsp_status,
`ifdef ARB_GRANT_CNT_EN
    input  logic             i_cnt_clr,
    output logic [N*16-1:0]  o_grant_cnt,
`endif
    output logic             o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] C_LAT = 4'(LAT);

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [IDW-1:0] pend_id_q, pend_id_d;
    logic [M-1:0]   arg_a_q, arg_a_d;
    logic [M-1:0]   arg_b_q, arg_b_d;
    logic [3:0]     op_q, op_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [M-1:0]   rsp_result_q, rsp_result_d;
    logic [3:0]     rsp_status_q, rsp_status_d;

    logic           w_win_found;
    logic [IDW-1:0] w_win_id;
    logic           w_handshake;

    // First valid requester at or after the pointer, wrapping modulo N.
    always_comb begin
        w_win_found = 1'b0;
        w_win_id    = '0;
        for (int i = 0; i < N; i++) begin
            if (!w_win_found && req_valid[(int'(ptr_q) + i) % N]) begin
                w_win_found = 1'b1;
                w_win_id    = IDW'((int'(ptr_q) + i) % N);
            end
        end
    end

    // Reset gating keeps req_ready at 0 while reset is held.
    assign w_handshake = (state_q == S_IDLE) && w_win_found && i_reset;

    always_comb begin
        req_ready = '0;
        if (w_handshake) begin
            req_ready[w_win_id] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        pend_id_d    = pend_id_q;
        arg_a_d      = arg_a_q;
        arg_b_d      = arg_b_q;
        op_d         = op_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_status_d = rsp_status_q;
        unique case (state_q)
            S_IDLE: begin
                if (w_handshake) begin
                    arg_a_d   = req_A[int'(w_win_id)*M +: M];
                    arg_b_d   = req_B[int'(w_win_id)*M +: M];
                    op_d      = req_op[int'(w_win_id)*4 +: 4];
                    pend_id_d = w_win_id;
                    ptr_d     = (int'(w_win_id) == N-1) ? '0 : w_win_id + 1'b1;
                    cnt_d     = C_LAT;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rsp_result_d = i_result;
                    rsp_status_d = i_status;
                    rsp_id_d     = pend_id_q;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            pend_id_q    <= '0;
            arg_a_q      <= '0;
            arg_b_q      <= '0;
            op_q         <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_status_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            pend_id_q    <= pend_id_d;
            arg_a_q      <= arg_a_d;
            arg_b_q      <= arg_b_d;
            op_q         <= op_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign o_arg_A    = arg_a_q;
    assign o_arg_B    = arg_b_q;
    assign o_op       = op_q;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_status = rsp_status_q;
    assign o_busy     = (state_q != S_IDLE);

`ifdef ARB_GRANT_CNT_EN
    // Saturating per-requester grant counters; clear beats a same-cycle grant.
    generate
        for (genvar k = 0; k < N; k++) begin : g_gcnt
            logic [15:0] gcnt_q;
            always_ff @(posedge clk or negedge i_reset) begin
                if (!i_reset) begin
                    gcnt_q <= '0;
                end else if (i_cnt_clr) begin
                    gcnt_q <= '0;
                end else if (w_handshake && (w_win_id == IDW'(k)) && (gcnt_q != 16'hFFFF)) begin
                    gcnt_q <= gcnt_q + 16'd1;
                end
            end
            assign o_grant_cnt[k*16 +: 16] = gcnt_q;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_arith_rr_scheduler.sv
`default_nettype none
// =============================================================================
// Module : tb_arith_rr_scheduler -- bench for arith_rr_scheduler with a LAT=1
//          stub arithmetic unit and a transaction-level reference model.
// Rev    : 1.0
// =============================================================================
module tb_arith_rr_scheduler;

    localparam int M   = 32;
    localparam int N   = 4;
    localparam int LAT = 1;
    localparam int IDW = $clog2(N);

    logic             clk = 1'b0;
    logic             i_reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*M-1:0]   req_A;
    logic [N*M-1:0]   req_B;
    logic [N*4-1:0]   req_op;
    logic [M-1:0]     o_arg_A;
    logic [M-1:0]     o_arg_B;
    logic [3:0]       o_op;
    logic [M-1:0]     i_result;
    logic [3:0]       i_status;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [M-1:0]     rsp_result;
    logic [3:0]       rsp_status;
    logic             o_busy;
`ifdef ARB_GRANT_CNT_EN
    logic             i_cnt_clr;
    logic [N*16-1:0]  o_grant_cnt;
`endif

    arith_rr_scheduler #(.M(M), .N(N), .LAT(LAT)) dut (
        .clk        (clk),
        .i_reset    (i_reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_A      (req_A),
        .req_B      (req_B),
        .req_op     (req_op),
        .o_arg_A    (o_arg_A),
        .o_arg_B    (o_arg_B),
        .o_op       (o_op),
        .i_result   (i_result),
        .i_status   (i_status),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_status (rsp_status),
`ifdef ARB_GRANT_CNT_EN
        .i_cnt_clr  (i_cnt_clr),
        .o_grant_cnt(o_grant_cnt),
`endif
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    // Arithmetic behaviour shared by the stub unit and the reference model.
    function automatic logic [M+3:0] ref_op(input logic [M-1:0] a, input logic [M-1:0] b,
                                            input logic [3:0] op);
        case (op)
            4'h0:    return {4'h0, a + b};
            4'h1:    return {(a < b) ? 4'h1 : 4'h0, a - b};
            default: return {4'h2, a ^ b};
        endcase
    endfunction

    logic [M+3:0] stub_q;
    always @(posedge clk) stub_q <= ref_op(o_arg_A, o_arg_B, o_op);
    assign i_result = stub_q[M-1:0];
    assign i_status = stub_q[M+3:M];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a grant at edge E owns the unit; its response is due
    // from edge E+LAT+1 and the unit is free again after the accepting edge.
    int           m_ptr, m_e, m_rsp_at, m_id;
    bit           m_busy;
    logic [M+3:0] m_exp;
    logic [M-1:0] m_a, m_b;
    logic [3:0]   m_op;
    int           m_cnt [N];
    int           q_rsp [$];

    task automatic model_reset();
        m_ptr = 0; m_e = 0; m_rsp_at = 0; m_id = 0; m_busy = 0;
        m_exp = '0; m_a = '0; m_b = '0; m_op = '0;
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
    endtask

    task automatic tick();
        logic [N-1:0] exp_ready;
        int           win;
        bit           rv;
        @(negedge clk);
        exp_ready = '0;
        win = -1;
        if (!m_busy) begin
            for (int i = 0; i < N; i++) begin
                int idx = (m_ptr + i) % N;
                if (win < 0 && req_valid[idx]) win = idx;
            end
        end
        if (win >= 0) exp_ready[win] = 1'b1;
        rv = m_busy && (m_e >= m_rsp_at);
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("o_busy", 64'(o_busy), 64'(m_busy));
        chk("rsp_valid", 64'(rsp_valid), 64'(rv));
        chk("unit_args", {28'd0, o_arg_A, o_op}, {28'd0, m_a, m_op});
        chk("unit_argB", 64'(o_arg_B), 64'(m_b));
        if (rv) begin
            chk("rsp_id", 64'(rsp_id), 64'(m_id));
            chk("rsp_result", 64'(rsp_result), 64'(m_exp[M-1:0]));
            chk("rsp_status", 64'(rsp_status), 64'(m_exp[M+3:M]));
        end
`ifdef ARB_GRANT_CNT_EN
        begin
            logic [N*16-1:0] exp_cnt;
            for (int k = 0; k < N; k++) exp_cnt[k*16 +: 16] = 16'(m_cnt[k]);
            chk("grant_cnt", 64'(o_grant_cnt), 64'(exp_cnt));
            if (i_cnt_clr) begin
                for (int k = 0; k < N; k++) m_cnt[k] = 0;
            end else if (win >= 0 && m_cnt[win] < 65535) begin
                m_cnt[win] = m_cnt[win] + 1;
            end
        end
`endif
        m_e++;
        if (win >= 0) begin
            m_busy   = 1;
            m_id     = win;
            m_rsp_at = m_e + LAT + 1;
            m_a      = req_A[win*M +: M];
            m_b      = req_B[win*M +: M];
            m_op     = req_op[win*4 +: 4];
            m_exp    = ref_op(m_a, m_b, m_op);
            m_ptr    = (win + 1) % N;
        end else if (rv && rsp_ready) begin
            m_busy = 0;
            q_rsp.push_back(int'(rsp_id));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string t);
        chk({t, "_ready"}, 64'(req_ready), 64'd0);
        chk({t, "_args"}, {28'd0, o_arg_A, o_op}, 64'd0);
        chk({t, "_argB"}, 64'(o_arg_B), 64'd0);
        chk({t, "_rsp"}, {27'd0, rsp_valid, rsp_status, rsp_result}, 64'd0);
        chk({t, "_id_busy"}, {63'(rsp_id), o_busy}, 64'd0);
`ifdef ARB_GRANT_CNT_EN
        chk({t, "_gcnt"}, 64'(o_grant_cnt), 64'd0);
`endif
    endtask

    task automatic wait_rsp(input string t);
        for (int i = 0; i < 20 && !rsp_valid; i++) tick();
        chk({t, "_rv"}, 64'(rsp_valid), 64'd1);
    endtask

    initial begin
        int rr_exp [6] = '{0, 1, 2, 3, 0, 1};
        i_reset = 1'b1; req_valid = '0; req_A = '0; req_B = '0; req_op = '0; rsp_ready = 1'b0;
`ifdef ARB_GRANT_CNT_EN
        i_cnt_clr = 1'b0;
`endif
        model_reset();
        #2 i_reset = 1'b0;
        #1 chk_zero("reset");
        repeat (2) @(posedge clk);
        #1 i_reset = 1'b1;

        // Single request from requester 2.
        req_A[2*M +: M] = 32'd5; req_B[2*M +: M] = 32'd7; req_op[2*4 +: 4] = 4'h0;
        req_valid = 4'b0100; rsp_ready = 1'b1;
        #1 chk("single_ready2", 64'(req_ready[2]), 64'd1);
        tick();
        req_valid = '0;
        tick(); tick();
        chk("single_rv", 64'(rsp_valid), 64'd1);
        chk("single_id", 64'(rsp_id), 64'd2);
        chk("single_res", 64'(rsp_result), 64'd12);
        chk("single_st", 64'(rsp_status), 64'd0);
        tick();

        // Wrap from ptr=3 to 0 with a borrowing subtraction.
        req_A[3*M +: M] = 32'd1; req_B[3*M +: M] = 32'd2; req_op[3*4 +: 4] = 4'h1;
        req_A[0 +: M] = 32'd100; req_B[0 +: M] = 32'd23; req_op[0 +: 4] = 4'h0;
        req_valid = 4'b1001;
        wait_rsp("wrap1");
        chk("wrap1_id", 64'(rsp_id), 64'd3);
        chk("wrap1_res", 64'(rsp_result), 64'hFFFF_FFFF);
        chk("wrap1_st", 64'(rsp_status), 64'd1);
        tick();
        wait_rsp("wrap2");
        chk("wrap2_id", 64'(rsp_id), 64'd0);
        req_valid = '0;
        tick();

        // Reset while waiting on the unit, then round robin from requester 0.
        req_valid = 4'b0010;
        tick();
        chk("prerst_busy", 64'(o_busy), 64'd1);
        req_valid = 4'b1111;
        for (int k = 0; k < N; k++) begin
            req_A[k*M +: M] = $urandom; req_B[k*M +: M] = $urandom; req_op[k*4 +: 4] = 4'(k % 2);
        end
        #2 i_reset = 1'b0;
        #1 chk_zero("midrst");
        repeat (2) begin
            @(negedge clk);
            chk("midrst_rv", 64'(rsp_valid), 64'd0);
        end
        @(posedge clk);
        #1 i_reset = 1'b1;
        model_reset();
        q_rsp.delete();
        for (int i = 0; i < 200 && q_rsp.size() < 6; i++) tick();
        req_valid = '0;
        chk("rr_count", 64'(q_rsp.size()), 64'd6);
        for (int i = 0; i < 6 && i < q_rsp.size(); i++) chk("rr_seq", 64'(q_rsp[i]), 64'(rr_exp[i]));
`ifdef ARB_GRANT_CNT_EN
        chk("rr_gcnt", 64'(o_grant_cnt), {16'd1, 16'd1, 16'd2, 16'd2});
`endif

        // Response backpressure with requesters 0 and 1 pending (ptr=2).
        req_valid = 4'b0011; rsp_ready = 1'b0;
        wait_rsp("bp1");
        chk("bp1_id", 64'(rsp_id), 64'd0);
        repeat (5) begin
            tick();
            chk("bp_ready", 64'(req_ready), 64'd0);
            chk("bp_busy", 64'(o_busy), 64'd1);
            chk("bp_rv", 64'(rsp_valid), 64'd1);
        end
        rsp_ready = 1'b1;
        tick();
        wait_rsp("bp2");
        chk("bp2_id", 64'(rsp_id), 64'd1);
        req_valid = '0;
        tick();

        // Randomised traffic against the model.
        for (int t = 0; t < 600; t++) begin
            req_valid = 4'($urandom_range(0, 15));
            for (int k = 0; k < N; k++) begin
                req_A[k*M +: M] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
                req_B[k*M +: M] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
                req_op[k*4 +: 4] = 4'($urandom_range(0, 3));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
`ifdef ARB_GRANT_CNT_EN
            i_cnt_clr = ($urandom_range(0, 31) == 0);
`endif
            tick();
        end
        req_valid = '0; rsp_ready = 1'b1;
`ifdef ARB_GRANT_CNT_EN
        i_cnt_clr = 1'b0;
`endif
        repeat (6) tick();
        chk("drain_busy", 64'(o_busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
